// File: rtl/imm_encoder.sv
// Packs an immediate into a base instruction word (I/S/U/B/J formats) through a
// 2-stage valid/ready pipeline, flagging immediates the format cannot represent.
module imm_encoder (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  imm_src,
  input  logic        u_sel,
  input  logic [31:0] imm,
  input  logic [31:0] base_instr,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] instr_out,
  output logic        range_err,
  output logic [7:0]  err_count
);

  typedef enum logic [1:0] {
    IMM_I  = 2'b00,
    IMM_SU = 2'b01,
    IMM_B  = 2'b10,
    IMM_J  = 2'b11
  } imm_src_e;

  logic        r_s1_valid;
  imm_src_e    r_s1_src;
  logic        r_s1_usel;
  logic [31:0] r_s1_imm;
  logic [31:0] r_s1_base;
  logic        r_s1_err;

  logic        w_s2_load;
  logic        w_range_err;
  logic [31:0] w_packed;

  assign w_s2_load = !out_valid || out_ready;
  assign in_ready  = !r_s1_valid || w_s2_load;

  // Representability check on the incoming request; the result rides along in S1.
  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    w_range_err = 1'b0;
    case (imm_src)
      IMM_I:  w_range_err = !(&imm[31:11] || ~|imm[31:11]);
      IMM_SU: w_range_err = u_sel ? |imm[11:0] : !(&imm[31:11] || ~|imm[31:11]);
      IMM_B:  w_range_err = !(&imm[31:12] || ~|imm[31:12]) || imm[0];
      IMM_J:  w_range_err = !(&imm[31:20] || ~|imm[31:20]) || imm[0];
      default: w_range_err = 1'b0;
    endcase
  end

  always_comb begin
    w_packed = r_s1_base;
    case (r_s1_src)
      IMM_I: w_packed[31:20] = r_s1_imm[11:0];
      IMM_SU: begin
        if (r_s1_usel) begin
          w_packed[31:12] = r_s1_imm[31:12];
        end else begin
          w_packed[31:25] = r_s1_imm[11:5];
          w_packed[11:7]  = r_s1_imm[4:0];
        end
      end
      IMM_B: begin
        w_packed[31]    = r_s1_imm[12];
        w_packed[30:25] = r_s1_imm[10:5];
        w_packed[11:8]  = r_s1_imm[4:1];
        w_packed[7]     = r_s1_imm[11];
      end
      IMM_J: begin
        w_packed[31]    = r_s1_imm[20];
        w_packed[30:21] = r_s1_imm[10:1];
        w_packed[20]    = r_s1_imm[11];
        w_packed[19:12] = r_s1_imm[19:12];
      end
      default: ;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every register samples
  // the pre-edge values of the others, independent of block ordering.
  // NOTE: S1 payload is reset too, so the packer never sees X after reset even
  // though only the valid bit is functionally required to clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_src   <= IMM_I;
      r_s1_usel  <= 1'b0;
      r_s1_imm   <= '0;
      r_s1_base  <= '0;
      r_s1_err   <= 1'b0;
    end else if (in_ready) begin
      r_s1_valid <= in_valid;
      if (in_valid) begin
        r_s1_src  <= imm_src_e'(imm_src);
        r_s1_usel <= u_sel;
        r_s1_imm  <= imm;
        r_s1_base <= base_instr;
        r_s1_err  <= w_range_err;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      instr_out <= '0;
      range_err <= 1'b0;
    end else if (w_s2_load) begin
      out_valid <= r_s1_valid;
      if (r_s1_valid) begin
        instr_out <= w_packed;
        range_err <= r_s1_err;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_count <= '0;
    end else if (out_valid && out_ready && range_err && (err_count != 8'hFF)) begin
      err_count <= err_count + 8'd1;
    end
  end

endmodule

// File: doc/imm_encoder.md
IMM_ENCODER -- requirements
Module: imm_encoder

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset; ports `clk` and `rst_n`.
REQ-002 SHALL expose these ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  request valid
- in_ready  out  1  request accepted when in_valid & in_ready at clk rise
- imm_src  in  2  00 I, 01 S/U, 10 B, 11 J (same coding as the immediate extender's ImmSrc)
- u_sel  in  1  with imm_src=01: 0 S-type, 1 U-type (plays the role of opcode bit 4)
- imm  in  32  immediate value to pack
- base_instr  in  32  instruction carrying the non-immediate fields
- out_valid  out  1  encoded word valid
- out_ready  in  1  downstream accepts when out_valid & out_ready
- instr_out  out  32  encoded instruction
- range_err  out  1  qualifies instr_out: imm not representable
- err_count  out  8  saturating count of emitted words with range_err=1

Function
REQ-003 SHALL be a 2-stage valid/ready pipeline: S1 registers the request and the range check; S2 registers the packed word.
REQ-004 SHALL present instr_out/range_err at out_valid exactly 2 cycles after acceptance when out_ready is held high.
REQ-005 S2 SHALL load when S2 is empty or out_ready=1; S1 SHALL advance into S2 under the same condition.
REQ-006 in_ready SHALL equal !S1_valid | S2-load condition; full throughput is 1 word/cycle with out_ready=1.
REQ-007 SHALL not drop, duplicate or reorder words; outputs SHALL hold stable while out_valid=1 & out_ready=0.
REQ-008 SHALL copy all base_instr bits not overwritten below unchanged into instr_out.
REQ-009 SHALL pack I-type as instr[31:20]=imm[11:0].
REQ-010 SHALL pack S-type as instr[31:25]=imm[11:5] and instr[11:7]=imm[4:0].
REQ-011 SHALL pack U-type as instr[31:12]=imm[31:12].
REQ-012 SHALL pack B-type as [31]=imm[12], [7]=imm[11], [30:25]=imm[10:5], [11:8]=imm[4:1].
REQ-013 SHALL pack J-type as [31]=imm[20], [19:12]=imm[19:12], [20]=imm[11], [30:21]=imm[10:1].
REQ-014 range_err SHALL be set for each type as follows:
- I/S: imm[31:11] not all equal
- U: imm[11:0] != 0
- B: imm[31:12] not all equal, or imm[0]=1
- J: imm[31:20] not all equal, or imm[0]=1
REQ-015 On range_err the word SHALL still be emitted, packed from the truncated bits per REQ-009..013.
REQ-016 With range_err=0, sign/zero extension of instr_out by the immediate extender SHALL reproduce imm exactly.
REQ-017 err_count SHALL increment on each out_valid & out_ready & range_err handshake and saturate at 255.
REQ-018 Inputs other than in_valid SHALL be ignored when no handshake occurs.

Reset
REQ-019 When rst_n=0, the block SHALL asynchronously clear S1/S2 valid, out_valid=0, instr_out=0, range_err=0 and err_count=0.
REQ-020 After reset, in_ready SHALL be 1.
REQ-021 Reset mid-operation SHALL discard all in-flight words; none SHALL appear after reset releases.
REQ-022 Deassertion of rst_n SHALL be sampled synchronously; the first handshake is possible on the first clk rise with rst_n=1.

Verification
REQ-023 I-type: imm_src=00, imm=0xFFFFFFFF, base=0x00000093 -> instr_out=0xFFF00093, range_err=0, 2 cycles later.
REQ-024 B-type: imm_src=10, imm=0xFFFFFFFC, base=0x00000063 -> 0xFE000EE3, range_err=0; imm=0x00000003 -> range_err=1.
REQ-025 U/J: imm_src=01, u_sel=1, imm=0x12345000, base=0x000000B7 -> 0x123450B7; imm=0x12345001 -> range_err=1. imm_src=11, imm=0x00000800, base=0x000000EF -> 0x001000EF.
REQ-026 Backpressure: stream of 4 words with out_ready=0 for 5 cycles -> in_ready=0 after 2 accepted; all 4 delivered in order once out_ready=1, with no bubbles.
REQ-027 Error count: 300 back-to-back I-type words with imm=0x00000800 -> each has range_err=1; err_count reaches 255 and holds.
REQ-028 Reset with 2 words in flight -> out_valid=0 immediately; no stale word emitted after release; err_count=0.
